serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
Bit-serial adder/subtractor controller that time-multiplexes a single 1-bit full-adder cell over WIDTH cycles to add or subtract two WIDTH-bit operands.
- Sequences operand shift registers, a carry flip-flop and a bit counter.
- Presents the result with a start/done handshake.
- Sits between a register-file/ALU front end and the full-adder cell as the low-area arithmetic path.

Parameters:
WIDTH, 8, operand/result width in bits (legal range 1..32)
CNT_W, derived localparam = max(1, clog2(WIDTH)), bit-counter width (not user-settable)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only when ready=1
sub  in  1  1 = compute a-b (b inverted, carry-in forced 1, cin ignored); 0 = a+b+cin
a  in  WIDTH  operand A, captured on accepted start
b  in  WIDTH  operand B, captured on accepted start
cin  in  1  carry-in for add, captured on accepted start
ready  out  1  high in IDLE only
busy  out  1  high in RUN only
done  out  1  one-cycle pulse, result valid
sum  out  WIDTH  result; holds last result until next completion
cout  out  1  carry out of MSB (sub: 1 = no borrow)
ovf  out  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, ready=1, busy=0, done=0, sum=0, cout=0, ovf=0.
  - Counter, shift registers and carry FF cleared.
  - Reset mid-RUN aborts the operation with no done pulse; the first accepted start after release behaves normally.
- States: IDLE, RUN, DONE (encodings in shared defs).
- IDLE, start=1 at edge E0:
  - a_sh<=a; b_sh<=sub ? ~b : b; carry<=sub ? 1 : cin; cnt<=0; state->RUN.
  - start=0 stays in IDLE.
- RUN, each edge:
  - The full-adder cell takes a_sh[0], b_sh[0], carry.
  - sum_sh shifts right with the cell sum bit entering the MSB.
  - a_sh and b_sh shift right; carry<=cell carry; cnt<=cnt+1.
  - When cnt==WIDTH-2, the cell carry-out is also stored as c_msb_in (carry into MSB). For WIDTH=1, c_msb_in = initial carry.
  - At the edge where cnt==WIDTH-1 (edge E_WIDTH):
    - sum<={cell_sum, sum_sh[WIDTH-1:1]}, cout<=cell carry, ovf<=c_msb_in ^ cell carry.
    - done<=1, state->DONE.
- DONE:
  - One cycle with done=1, ready=0, busy=0.
  - Next edge: done<=0, state->IDLE.
- Latency: done is high during the cycle after edge E_WIDTH, WIDTH edges after the start edge. Minimum start-to-start spacing is WIDTH+2 cycles.
- start while RUN or DONE is ignored; it is neither queued nor allowed to corrupt operands.
- Operand inputs a/b/sub/cin are don't-care except at the accepting edge.
- sum/cout/ovf change only at the completion edge and at reset.
- Counter never exceeds WIDTH-1; no wrap past WIDTH.
- WIDTH=1: RUN lasts one edge; done asserts after E1.

Decomposition:
- Shared defs file: state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2; a clog2 helper function.
- One sub-module, fa_bit: purely combinational 1-bit full adder (s = a^b^ci, co = ab+a·ci+b·ci), instantiated once.
- The controller holds the FSM, counter, shift registers and result registers.

Test Plan:
1. WIDTH=8, a=0x5A, b=0x3C, sub=0, cin=0 -> done pulse exactly 8 cycles after start edge; sum=0x96, cout=0, ovf=1; ready low for 9 cycles.
2. a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Then a=0x7F, b=0x00, cin=1 -> sum=0x80, cout=0, ovf=1.
3. sub=1, a=0x10, b=0x20 (cin=1 applied, must be ignored) -> sum=0xF0, cout=0, ovf=0. Then a=0x80, b=0x01 -> sum=0x7F, cout=1, ovf=1.
4. start held high continuously with changing a/b -> operations back-to-back every 10 cycles (WIDTH+2); each result matches operands captured at its own accepting edge; mid-RUN changes have no effect.
5. rst_n pulsed low at cycle 4 of RUN -> outputs immediately 0/ready=1 asynchronously; no done; the next start (0x01+0x01) gives sum=0x02.
6. WIDTH=1 build: a=1, b=1, cin=1 -> done after 1 edge; sum=1, cout=1, ovf=0. Random 1000-vector compare for WIDTH=8 and WIDTH=13 against a behavioural reference model.

Source files
------------

// File: rtl/serial_add_ctrl_pkg.sv
// serial_add_ctrl_pkg: FSM state encodings and a clog2 helper shared by the serial adder files
package serial_add_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/serial_add_ctrl_fa_bit.sv
// fa_bit: combinational 1-bit full adder (a, b, ci -> s, co)
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add/sub over WIDTH cycles; start/sub/a/b/cin in, ready/busy/done/sum/cout/ovf out
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CNT_W = clog2(WIDTH) > 1 ? clog2(WIDTH) : 1;
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_sh, b_sh, sum_nx;
  logic carry, c_msb_in, cell_s, cell_co, last, accept;
  fa_bit u_fa (
    .a (a_sh[0]),
    .b (b_sh[0]),
    .ci(carry),
    .s (cell_s),
    .co(cell_co)
  );
  assign last   = cnt == CNT_W'(WIDTH - 1);
  assign accept = state == ST_IDLE && start;
  always_comb begin
    state_nx = state == ST_IDLE ? (start ? ST_RUN : ST_IDLE) :
               state == ST_RUN  ? (last ? ST_DONE : ST_RUN) : ST_IDLE;
    ready    = state == ST_IDLE;
    busy     = state == ST_RUN;
    done     = state == ST_DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_IDLE;
    else state <= state_nx;
  if (WIDTH == 1) begin : g_w1
    assign sum_nx = cell_s;
  end else begin : g_wn
    logic [WIDTH-2:0] sum_sh;
    assign sum_nx = {cell_s, sum_sh};
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) sum_sh <= '0;
      else if (state == ST_RUN) sum_sh <= sum_nx[WIDTH-1:1];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt      <= '0;
      a_sh     <= '0;
      b_sh     <= '0;
      carry    <= 1'b0;
      c_msb_in <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      ovf      <= 1'b0;
    end else if (accept) begin
      cnt      <= '0;
      a_sh     <= a;
      b_sh     <= sub ? ~b : b;
      carry    <= sub | cin;
      c_msb_in <= sub | cin;
    end else if (state == ST_RUN) begin
      cnt   <= last ? cnt : cnt + 1'b1;
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      carry <= cell_co;
      if (int'(cnt) == WIDTH - 2) c_msb_in <= cell_co;
      if (last) begin
        sum  <= sum_nx;
        cout <= cell_co;
        ovf  <= c_msb_in ^ cell_co;
      end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: scoreboard bench for serial_add_ctrl at WIDTH 8, 13 and 1
module tb_serial_add_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  logic start8 = 0, sub8 = 0, cin8 = 0;
  logic [7:0] a8 = 0, b8 = 0, sum8;
  logic ready8, busy8, done8, cout8, ovf8;
  logic start13 = 0, sub13 = 0, cin13 = 0;
  logic [12:0] a13 = 0, b13 = 0, sum13;
  logic ready13, busy13, done13, cout13, ovf13;
  logic start1 = 0, sub1 = 0, cin1 = 0;
  logic [0:0] a1 = 0, b1 = 0, sum1;
  logic ready1, busy1, done1, cout1, ovf1;
  logic [33:0] sb8[$], sb13[$], sb1[$];
  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8), .cin(cin8),
    .ready(ready8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8));
  serial_add_ctrl #(.WIDTH(13)) dut13 (
    .clk(clk), .rst_n(rst_n), .start(start13), .sub(sub13), .a(a13), .b(b13), .cin(cin13),
    .ready(ready13), .busy(busy13), .done(done13), .sum(sum13), .cout(cout13), .ovf(ovf13));
  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1), .a(a1), .b(b1), .cin(cin1),
    .ready(ready1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1));
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [33:0] model(input int w, input logic s, input logic [31:0] a,
                                        input logic [31:0] b, input logic ci);
    logic [63:0] m, m1, bb, c0, full, low;
    m    = (64'd1 << w) - 64'd1;
    m1   = m >> 1;
    bb   = (s ? ~{32'b0, b} : {32'b0, b}) & m;
    c0   = {63'b0, s | ci};
    full = ({32'b0, a} & m) + bb + c0;
    low  = ({32'b0, a} & m1) + (bb & m1) + c0;
    return {low[w-1] ^ full[w], full[w], full[31:0] & m[31:0]};
  endfunction
  always @(negedge clk)
    if (done8) begin
      if (sb8.size() == 0) check("sb8_underflow", 64'(sb8.size()), 64'd1);
      else check("res8", 64'({ovf8, cout8, 24'b0, sum8}), 64'(sb8.pop_front()));
    end
  always @(negedge clk)
    if (done13) begin
      if (sb13.size() == 0) check("sb13_underflow", 64'(sb13.size()), 64'd1);
      else check("res13", 64'({ovf13, cout13, 19'b0, sum13}), 64'(sb13.pop_front()));
    end
  always @(negedge clk)
    if (done1) begin
      if (sb1.size() == 0) check("sb1_underflow", 64'(sb1.size()), 64'd1);
      else check("res1", 64'({ovf1, cout1, 31'b0, sum1}), 64'(sb1.pop_front()));
    end
  task automatic op8(input logic s, input logic [7:0] a, input logic [7:0] b, input logic ci);
    @(negedge clk);
    start8 = 1; sub8 = s; a8 = a; b8 = b; cin8 = ci;
    sb8.push_back(model(8, s, {24'b0, a}, {24'b0, b}, ci));
    @(negedge clk);
    start8 = 0; sub8 = ~s; a8 = ~a; b8 = ~b; cin8 = ~ci;
    for (int i = 0; i < 12 && !done8; i++) @(negedge clk);
    check("done8_seen", 64'(done8), 64'd1);
    @(negedge clk);
  endtask
  task automatic op13(input logic s, input logic [12:0] a, input logic [12:0] b, input logic ci);
    @(negedge clk);
    start13 = 1; sub13 = s; a13 = a; b13 = b; cin13 = ci;
    sb13.push_back(model(13, s, {19'b0, a}, {19'b0, b}, ci));
    @(negedge clk);
    start13 = 0; sub13 = ~s; a13 = ~a; b13 = ~b; cin13 = ~ci;
    for (int i = 0; i < 18 && !done13; i++) @(negedge clk);
    check("done13_seen", 64'(done13), 64'd1);
    @(negedge clk);
  endtask
  task automatic op1(input logic s, input logic a, input logic b, input logic ci);
    @(negedge clk);
    start1 = 1; sub1 = s; a1 = a; b1 = b; cin1 = ci;
    sb1.push_back(model(1, s, {31'b0, a}, {31'b0, b}, ci));
    @(negedge clk);
    start1 = 0; sub1 = ~s; a1 = ~a; b1 = ~b; cin1 = ~ci;
    for (int i = 0; i < 6 && !done1; i++) @(negedge clk);
    check("done1_seen", 64'(done1), 64'd1);
    @(negedge clk);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
  initial begin
    int lat, rlow, bcnt, last_acc, ndone;
    @(negedge clk);
    check("rst8", 64'({ready8, busy8, done8, cout8, ovf8, sum8}), 64'h1000);
    check("rst13", 64'({ready13, busy13, done13, cout13, ovf13, sum13}), 64'h20000);
    check("rst1", 64'({ready1, busy1, done1, cout1, ovf1, sum1}), 64'h20);
    rst_n = 1;
    @(negedge clk);
    start8 = 1; sub8 = 0; a8 = 8'h5A; b8 = 8'h3C; cin8 = 0;
    sb8.push_back(model(8, 1'b0, 32'h5A, 32'h3C, 1'b0));
    lat = -1; rlow = 0; bcnt = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      start8 = 0;
      if (done8 && lat < 0) lat = i - 1;
      if (!ready8) rlow++;
      if (busy8) bcnt++;
      if (i == 4) check("hold8_run", 64'(sum8), 64'h0);
    end
    check("lat8", 64'(lat), 64'd8);
    check("ready_low8", 64'(rlow), 64'd9);
    check("busy8", 64'(bcnt), 64'd8);
    op8(1'b0, 8'hFF, 8'h01, 1'b0);
    op8(1'b0, 8'h7F, 8'h00, 1'b1);
    repeat (3) @(negedge clk);
    check("hold8_idle", 64'(sum8), 64'h80);
    op8(1'b1, 8'h10, 8'h20, 1'b1);
    op8(1'b1, 8'h80, 8'h01, 1'b0);
    last_acc = -1;
    for (int i = 0; i <= 40; i++) begin
      @(negedge clk);
      start8 = 1; sub8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      if (ready8) begin
        sb8.push_back(model(8, sub8, {24'b0, a8}, {24'b0, b8}, cin8));
        if (last_acc >= 0) check("spacing8", 64'(i - last_acc), 64'd10);
        last_acc = i;
      end
    end
    @(negedge clk);
    start8 = 0;
    for (int i = 0; i < 30 && sb8.size() != 0; i++) @(negedge clk);
    check("drain8", 64'(sb8.size()), 64'd0);
    @(negedge clk);
    check("idle8_after_b2b", 64'(ready8), 64'd1);
    start8 = 1; sub8 = 0; a8 = 8'h33; b8 = 8'h44; cin8 = 0;
    @(negedge clk);
    start8 = 0;
    repeat (3) @(negedge clk);
    #2 rst_n = 0;
    #1 check("arst8", 64'({ready8, busy8, done8, cout8, ovf8, sum8}), 64'h1000);
    @(negedge clk);
    rst_n = 1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    check("abort_nodone8", 64'(ndone), 64'd0);
    op8(1'b0, 8'h01, 8'h01, 1'b0);
    check("after_abort8", 64'(sum8), 64'h02);
    @(negedge clk);
    start1 = 1; sub1 = 0; a1 = 1'b1; b1 = 1'b1; cin1 = 1;
    sb1.push_back(model(1, 1'b0, 32'h1, 32'h1, 1'b1));
    lat = -1; rlow = 0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      start1 = 0;
      if (done1 && lat < 0) lat = i - 1;
      if (!ready1) rlow++;
    end
    check("lat1", 64'(lat), 64'd1);
    check("ready_low1", 64'(rlow), 64'd2);
    for (int i = 0; i < 50; i++) op1(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    for (int i = 0; i < 1000; i++) op8(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
    for (int i = 0; i < 1000; i++) op13(1'($urandom), 13'($urandom), 13'($urandom), 1'($urandom));
    repeat (3) @(negedge clk);
    check("sb_empty", 64'(sb8.size() + sb13.size() + sb1.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
